// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start, DATA_W bits MSB-first, even parity, stop -> valid/ready word register.
// Latency: word or error pulse visible the cycle after the stop-bit strobe; bits advance only on en.
// Backpressure: a good frame arriving while valid&!ready is dropped with an overrun pulse.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in,
  input  logic              ready,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   sr, sr_d;
  logic                mismatch, mismatch_d;
  logic                good, ferr, perr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sr       <= sr_d;
      mismatch <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sr_d       = sr;
    mismatch_d = mismatch;
    good       = 1'b0;
    ferr       = 1'b0;
    perr       = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (!in) begin
            state_d = DATA;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end
        DATA: begin
          sr_d  = {sr[DATA_W-2:0], in};
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          mismatch_d = (^sr) ^ in;
          state_d    = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // Stop-bit error outranks parity, which outranks overrun.
          if (!in)           ferr = 1'b1;
          else if (mismatch) perr = 1'b1;
          else               good = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= perr;
      frame_err  <= ferr;
      overrun    <= good && valid && !ready;
      if (good && (!valid || ready)) begin
        out   <= sr;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8): hand-built frames, exact-cycle checks and pulse/word tallies.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset;
  logic       en;
  logic       in;
  logic       ready;
  logic [7:0] out;
  logic       valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int n_pe = 0;
  int n_fe = 0;
  int n_ov = 0;
  logic [7:0] acc_q[$];

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in         (in),
    .ready      (ready),
    .out        (out),
    .valid      (valid),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally pulse cycles and accepted words, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (parity_err) n_pe++;
      if (frame_err)  n_fe++;
      if (overrun)    n_ov++;
      if (valid && ready) acc_q.push_back(out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {1'b0, d, p, s};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step();
      en = 1'b1;
      in = bits[i];
      for (int g = 1; g < gap; g++) begin
        step();
        en = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    send_bits(frame(d, p, s), 11, gap);
  endtask

  logic [7:0] exp_acc [7];
  logic [10:0] f;

  initial begin
    exp_acc = '{8'hA5, 8'h3C, 8'h81, 8'h11, 8'hC3, 8'h0F, 8'hF0};
    reset = 1'b0;
    en    = 1'b0;
    in    = 1'b1;
    ready = 1'b1;
    #1;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_out",   32'(out),   32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Clean frame, continuous strobe
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    step();
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_out",   32'(out),   32'hA5);
    chk("a5_busy",  32'(busy),  32'h0);
    chk("a5_pulses", 32'({parity_err, frame_err, overrun}), 32'h0);
    en = 1'b0;
    step();
    chk("a5_consumed", 32'(valid), 32'h0);

    // Wrong parity, then the corrected frame
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    step();
    chk("3c_perr",  32'(parity_err), 32'h1);
    chk("3c_ferr",  32'(frame_err),  32'h0);
    chk("3c_valid", 32'(valid),      32'h0);
    en = 1'b0;
    step();
    chk("3c_perr_end", 32'(parity_err), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    step();
    chk("3c_ok_valid", 32'(valid), 32'h1);
    chk("3c_ok_out",   32'(out),   32'h3C);
    en = 1'b0;

    // Bad stop bit, line back to idle with strobes running, then good frame
    send_frame(8'h81, 1'b0, 1'b0, 1);
    step();
    chk("81_ferr",  32'(frame_err),  32'h1);
    chk("81_perr",  32'(parity_err), 32'h0);
    chk("81_valid", 32'(valid),      32'h0);
    in = 1'b1;
    step();
    step();
    chk("81_idle_busy", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 1);
    step();
    chk("81_ok_out", 32'(out), 32'h81);
    en = 1'b0;
    in = 1'b1;
    step();

    // Backpressure: second back-to-back frame overruns
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    step();
    chk("ov_pulse", 32'(overrun), 32'h1);
    chk("ov_valid", 32'(valid),   32'h1);
    chk("ov_out",   32'(out),     32'h11);
    en = 1'b0;
    in = 1'b1;
    step();
    chk("ov_pulse_end", 32'(overrun), 32'h0);
    chk("ov_hold_out",  32'(out),     32'h11);
    ready = 1'b1;
    step();
    chk("ov_drain_valid", 32'(valid), 32'h0);
    chk("ov_drain_out",   32'(out),   32'h11);

    // Sparse strobe, reset mid-frame, then a fresh frame
    f = frame(8'h5A, 1'b0, 1'b1);
    send_bits(f >> 7, 4, 4);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),  32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    step();
    step();
    chk("arst_busy_hold", 32'(busy), 32'h0);
    reset = 1'b1;
    en = 1'b0;
    in = 1'b1;
    step();
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    step();
    chk("c3_busy", 32'(busy), 32'h0);

    // Consume and reload on the same edge
    ready = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b1, 1);
    step();
    chk("0f_valid", 32'(valid), 32'h1);
    chk("0f_out",   32'(out),   32'h0F);
    en = 1'b0;
    in = 1'b1;
    f = frame(8'hF0, 1'b0, 1'b1);
    send_bits(f >> 1, 10, 1);
    step();
    en = 1'b1;
    in = 1'b1;
    ready = 1'b1;
    step();
    chk("swap_valid", 32'(valid),   32'h1);
    chk("swap_out",   32'(out),     32'hF0);
    chk("swap_ov",    32'(overrun), 32'h0);
    en = 1'b0;
    step();
    chk("swap_drain", 32'(valid), 32'h0);
    step();

    chk("tot_perr", 32'(n_pe), 32'h1);
    chk("tot_ferr", 32'(n_fe), 32'h1);
    chk("tot_ov",   32'(n_ov), 32'h1);
    chk("acc_count", 32'(acc_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < acc_q.size()) chk($sformatf("acc_%0d", i), 32'(acc_q[i]), 32'(exp_acc[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
